// File: rtl/ili9341_init_seq.sv
// ILI9341 init sequencer: walks an init ROM of command/data/delay/end entries and
// hands each command/data word to a bus driver. Optional panel reset pulse: INIT_HW_RESET_EN.

module ili9341_init_seq #(
  parameter int N_ENTRIES = 64,
  parameter int DW        = 8,
  parameter int DLY_UNIT  = 100000,
  parameter int RST_LOW   = 1000,
  parameter int RST_WAIT  = 12000000,
  localparam int AW       = $clog2(N_ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [DW+1:0] rom_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_dc,
  output logic [DW-1:0] tx_data,
  output logic          busy,
  output logic          done,
  output logic          lcd_rst_n
);

  // Longest delay entry in cycles; the counter is sized so it never overflows.
  localparam longint unsigned DLY_MAX = ((64'd1 << DW) - 64'd1) * 64'(DLY_UNIT);
  localparam int              CW      = $clog2(DLY_MAX + 64'd1);

  typedef enum logic [2:0] {
    IDLE, HWRST_LOW, HWRST_WAIT, FETCH, DECODE, SEND, DELAY, DONE
  } state_e;

  typedef enum logic [1:0] {
    ENT_CMD   = 2'b00,
    ENT_DATA  = 2'b01,
    ENT_DELAY = 2'b10,
    ENT_END   = 2'b11
  } entry_e;

  if (N_ENTRIES < 2) begin : g_bad_entries
    $error("ili9341_init_seq: N_ENTRIES must be at least 2");
  end
  if ((DW != 8) && (DW != 16)) begin : g_bad_dw
    $error("ili9341_init_seq: DW must be 8 or 16");
  end
  if ((DLY_UNIT < 1) || (RST_LOW < 1) || (RST_WAIT < 1)) begin : g_bad_timing
    $error("ili9341_init_seq: DLY_UNIT, RST_LOW and RST_WAIT must be at least 1");
  end

  state_e          state_q;
  logic [AW-1:0]   rom_addr_q;
  logic            tx_valid_q;
  logic            tx_dc_q;
  logic [DW-1:0]   tx_data_q;
  logic            busy_q;
  logic            done_q;
  logic [CW-1:0]   dly_cnt_q;

  entry_e          entry_type;
  logic [DW-1:0]   payload;
  logic [CW-1:0]   dly_cycles;
  logic            last_entry;
  logic            start_ok;
  state_e          adv_state;
  logic [AW-1:0]   adv_addr;

  assign entry_type = entry_e'(rom_data[DW+1:DW]);
  assign payload    = rom_data[DW-1:0];
  assign dly_cycles = CW'(payload) * CW'(DLY_UNIT);

  // Where the walk goes after a finished send or delay: next entry, or stop at the last one.
  assign last_entry = (rom_addr_q == AW'(N_ENTRIES - 1));
  assign adv_state  = last_entry ? DONE : FETCH;
  assign adv_addr   = last_entry ? rom_addr_q : rom_addr_q + 1'b1;
  assign start_ok   = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef INIT_HW_RESET_EN
  localparam int HW_MAX = (RST_LOW > RST_WAIT) ? RST_LOW : RST_WAIT;
  localparam int HW_CW  = $clog2(HW_MAX + 1);

  logic [HW_CW-1:0] hw_cnt_q;
  logic             lcd_rst_n_q;

  assign lcd_rst_n = lcd_rst_n_q;
`else
  assign lcd_rst_n = 1'b1;
`endif

  // NOTE: every register below uses <= so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rom_addr_q  <= '0;
      tx_valid_q  <= 1'b0;
      tx_dc_q     <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dly_cnt_q   <= '0;
`ifdef INIT_HW_RESET_EN
      hw_cnt_q    <= '0;
      lcd_rst_n_q <= 1'b1;
`endif
    end else if (start_ok) begin
      rom_addr_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
      tx_valid_q <= 1'b0;
`ifdef INIT_HW_RESET_EN
      state_q     <= HWRST_LOW;
      lcd_rst_n_q <= 1'b0;
      hw_cnt_q    <= HW_CW'(RST_LOW - 1);
`else
      state_q    <= FETCH;
`endif
    end else begin
      case (state_q)
`ifdef INIT_HW_RESET_EN
        HWRST_LOW: begin
          if (hw_cnt_q == '0) begin
            lcd_rst_n_q <= 1'b1;
            hw_cnt_q    <= HW_CW'(RST_WAIT - 1);
            state_q     <= HWRST_WAIT;
          end else begin
            hw_cnt_q <= hw_cnt_q - 1'b1;
          end
        end

        HWRST_WAIT: begin
          if (hw_cnt_q == '0) begin
            state_q <= FETCH;
          end else begin
            hw_cnt_q <= hw_cnt_q - 1'b1;
          end
        end
`endif

        // rom_addr is already on the ROM; its data is valid while in DECODE.
        FETCH: state_q <= DECODE;

        DECODE: begin
          case (entry_type)
            ENT_CMD, ENT_DATA: begin
              tx_dc_q   <= (entry_type == ENT_DATA);
              tx_data_q <= payload;
              state_q   <= SEND;
            end
            ENT_DELAY: begin
              if (payload == '0) begin
                state_q    <= adv_state;
                rom_addr_q <= adv_addr;
                busy_q     <= ~last_entry;
                done_q     <= last_entry;
              end else begin
                dly_cnt_q <= dly_cycles - 1'b1;
                state_q   <= DELAY;
              end
            end
            default: begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          endcase
        end

        // First SEND cycle raises tx_valid; the word then holds until the driver takes it.
        SEND: begin
          if (!tx_valid_q) begin
            tx_valid_q <= 1'b1;
          end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= adv_state;
            rom_addr_q <= adv_addr;
            busy_q     <= ~last_entry;
            done_q     <= last_entry;
          end
        end

        DELAY: begin
          if (dly_cnt_q == '0) begin
            state_q    <= adv_state;
            rom_addr_q <= adv_addr;
            busy_q     <= ~last_entry;
            done_q     <= last_entry;
          end else begin
            dly_cnt_q <= dly_cnt_q - 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  assign rom_addr = rom_addr_q;
  assign tx_valid = tx_valid_q;
  assign tx_dc    = tx_dc_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ili9341_init_seq.sv
// Self-checking bench for ili9341_init_seq: directed table rows, a mid-transfer reset,
// and randomized ROM images / tx_ready patterns against an entry-level timing model.

module tb_ili9341_init_seq;

  localparam int N        = 8;
  localparam int DW       = 8;
  localparam int DLY_U    = 4;
  localparam int RST_LOW  = 3;
  localparam int RST_WAIT = 5;
  localparam int AW       = 3;
  localparam int RW       = DW + 2;
  localparam int MAXC     = 2048;
  localparam logic [RW-1:0] END_E = 10'h300;
`ifdef INIT_HW_RESET_EN
  localparam int HW_OFF = RST_LOW + RST_WAIT;
`else
  localparam int HW_OFF = 0;
`endif

  typedef struct {
    string                 name;
    logic [N-1:0][RW-1:0]  img;
    int                    ready_mode;      // 0 always ready, 1 random, 2 low window
    int                    restart_at;      // edge of an extra start pulse, 0 = none
    int                    exp_xfer;
    int                    exp_first_rise;  // edges after the start-sampling edge 0
    int                    exp_done;
    int                    exp_addr;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_dc;
  logic [DW-1:0] tx_data;
  logic          busy;
  logic          done;
  logic          lcd_rst_n;

  logic [RW-1:0] rom_img [N];
  bit            ready_at [MAXC];

  int errors = 0;
  int checks = 0;

  int            exp_rise [$];
  int            exp_t [$];
  logic [DW:0]   exp_x [$];
  int            exp_done_edge;
  int            exp_last_addr;
  int            obs_rise [$];
  int            obs_t [$];
  logic [DW:0]   obs_x [$];
  int            obs_done;

  vec_t vecs [4];

  ili9341_init_seq #(
    .N_ENTRIES (N),
    .DW        (DW),
    .DLY_UNIT  (DLY_U),
    .RST_LOW   (RST_LOW),
    .RST_WAIT  (RST_WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_dc     (tx_dc),
    .tx_data   (tx_data),
    .busy      (busy),
    .done      (done),
    .lcd_rst_n (lcd_rst_n)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data for an address appears one cycle after the address.
  always @(posedge clk) rom_data <= rom_img[rom_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0][RW-1:0] img8(input logic [RW-1:0] e0, e1, e2, e3,
                                                 e4, e5, e6, e7);
    return {e7, e6, e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic vec_t make_vec(input string name, input logic [N-1:0][RW-1:0] img,
                                    input int mode, restart, xfer, rise, dn, addr);
    vec_t v;
    v.name = name; v.img = img; v.ready_mode = mode; v.restart_at = restart;
    v.exp_xfer = xfer; v.exp_first_rise = rise; v.exp_done = dn; v.exp_addr = addr;
    return v;
  endfunction

  task automatic fill_ready(input int mode);
    for (int j = 0; j < MAXC; j++) begin
      case (mode)
        0:       ready_at[j] = 1'b1;
        1:       ready_at[j] = ($urandom_range(0, 3) != 0);
        default: ready_at[j] = !((j >= 5 + HW_OFF) && (j <= 9 + HW_OFF));
      endcase
    end
  endtask

  // Entry-level timing: a walk step starts on the edge the sequencer is fetching entry a.
  // A send shows tx_valid 3 edges later and completes on the first later edge with ready;
  // a delay costs 2 + P*DLY_U edges; an end entry finishes 2 edges after its fetch.
  task automatic build_model();
    int e, a, nxt, pl;
    bit fin;
    logic [1:0] ty;
    exp_rise.delete(); exp_t.delete(); exp_x.delete();
    e = 1 + HW_OFF; a = 0; fin = 0; exp_done_edge = 0; nxt = 0;
    while (!fin) begin
      ty = rom_img[a][RW-1:DW];
      pl = int'(rom_img[a][DW-1:0]);
      if (ty == 2'b11) begin
        exp_done_edge = e + 2;
        fin = 1;
      end else begin
        if (!ty[1]) begin
          nxt = e + 4;
          while ((nxt < MAXC - 1) && !ready_at[nxt]) nxt++;
          exp_rise.push_back(e + 3);
          exp_t.push_back(nxt);
          exp_x.push_back({ty[0], rom_img[a][DW-1:0]});
        end else begin
          nxt = e + 2 + pl * DLY_U;
        end
        if (a == N - 1) begin
          exp_done_edge = nxt;
          fin = 1;
        end else begin
          a++;
          e = nxt;
        end
      end
    end
    exp_last_addr = a;
  endtask

  // Called at #1 after a rising edge; the start pulse is sampled on the next edge (edge 1).
  task automatic run_case(input string name, input int restart_at);
    int last, k, busy_err, done_err, lcd_err, stab_err;
    bit prev_valid, prev_xfer, exp_lcd, exp_busy;
    logic [DW:0] prev_word;
    build_model();
    obs_rise.delete(); obs_t.delete(); obs_x.delete();
    obs_done = -1; busy_err = 0; done_err = 0; lcd_err = 0; stab_err = 0;
    prev_valid = 0; prev_xfer = 0; prev_word = '0;
    last = exp_done_edge + 4;
    if (last > MAXC - 2) last = MAXC - 2;
    for (int j = 1; j <= last; j++) begin
      tx_ready = ready_at[j];
      start    = (j == 1) || (j == restart_at);
      @(negedge clk);
      k = j - 1;
      exp_busy = (k >= 1) && (k < exp_done_edge);
      if (busy !== exp_busy) busy_err++;
      if ((k >= 1) && (done !== (k >= exp_done_edge))) done_err++;
      if ((k >= 1) && (obs_done < 0) && (done === 1'b1)) obs_done = k;
`ifdef INIT_HW_RESET_EN
      exp_lcd = !((k >= 1) && (k < 1 + RST_LOW));
`else
      exp_lcd = 1'b1;
`endif
      if (lcd_rst_n !== exp_lcd) lcd_err++;
      if (prev_valid && !prev_xfer && (!tx_valid || ({tx_dc, tx_data} !== prev_word)))
        stab_err++;
      if (tx_valid && !prev_valid) obs_rise.push_back(k);
      prev_xfer = tx_valid && tx_ready;
      if (prev_xfer) begin
        obs_t.push_back(j);
        obs_x.push_back({tx_dc, tx_data});
      end
      prev_valid = tx_valid;
      prev_word  = {tx_dc, tx_data};
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check($sformatf("%s xfer count", name), obs_x.size(), exp_x.size());
    check($sformatf("%s rise count", name), obs_rise.size(), exp_rise.size());
    for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++) begin
      check($sformatf("%s xfer%0d word", name, i), obs_x[i], exp_x[i]);
      check($sformatf("%s xfer%0d edge", name, i), obs_t[i], exp_t[i]);
    end
    for (int i = 0; i < exp_rise.size() && i < obs_rise.size(); i++)
      check($sformatf("%s rise%0d edge", name, i), obs_rise[i], exp_rise[i]);
    check($sformatf("%s done edge", name), obs_done, exp_done_edge);
    check($sformatf("%s busy cycles wrong", name), busy_err, 0);
    check($sformatf("%s done cycles wrong", name), done_err, 0);
    check($sformatf("%s lcd_rst_n cycles wrong", name), lcd_err, 0);
    check($sformatf("%s unstable while waiting", name), stab_err, 0);
    check($sformatf("%s final rom_addr", name), rom_addr, exp_last_addr);
  endtask

  initial begin
    int w;
    rst = 1'b1; start = 1'b0; tx_ready = 1'b0;
    for (int a = 0; a < N; a++) rom_img[a] = END_E;

    vecs[0] = make_vec("cb_39", img8(10'h0CB, 10'h139, END_E, END_E, END_E, END_E, END_E, END_E),
                       0, 0, 2, 4, 11, 2);
    vecs[1] = make_vec("delays", img8(10'h001, 10'h203, 10'h002, 10'h200, 10'h003, END_E, END_E,
                       END_E), 0, 0, 3, 4, 31, 5);
    vecs[2] = make_vec("no_end", img8(10'h02A, 10'h100, 10'h100, 10'h100, 10'h1EF, 10'h02B,
                       10'h101, 10'h13F), 0, 10, 8, 4, 33, 7);
    vecs[3] = make_vec("stall", img8(10'h011, END_E, END_E, END_E, END_E, END_E, END_E, END_E),
                       2, 0, 1, 4, 12, 1);

    repeat (2) @(posedge clk);
    #1;
    check("reset tx_valid", tx_valid, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset rom_addr", rom_addr, 0);
    check("reset lcd_rst_n", lcd_rst_n, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      for (int a = 0; a < N; a++) rom_img[a] = vecs[i].img[a];
      fill_ready(vecs[i].ready_mode);
      run_case(vecs[i].name, vecs[i].restart_at);
      check($sformatf("%s table xfers", vecs[i].name), obs_x.size(), vecs[i].exp_xfer);
      check($sformatf("%s table first rise", vecs[i].name),
            (obs_rise.size() > 0) ? obs_rise[0] : -1, vecs[i].exp_first_rise + HW_OFF);
      check($sformatf("%s table done edge", vecs[i].name), obs_done, vecs[i].exp_done + HW_OFF);
      check($sformatf("%s table rom_addr", vecs[i].name), rom_addr, vecs[i].exp_addr);
    end

    // Reset while a word is waiting for tx_ready, then a clean restart from entry 0.
    for (int a = 0; a < N; a++) rom_img[a] = vecs[0].img[a];
    tx_ready = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    w = 0;
    while (!tx_valid && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("rst_mid tx_valid before reset", tx_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid tx_valid", tx_valid, 0);
    check("rst_mid tx_dc", tx_dc, 0);
    check("rst_mid tx_data", tx_data, 0);
    check("rst_mid busy", busy, 0);
    check("rst_mid done", done, 0);
    check("rst_mid rom_addr", rom_addr, 0);
    check("rst_mid lcd_rst_n", lcd_rst_n, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_ready(0);
    run_case("restart", 0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < N; a++) begin
        w = $urandom_range(0, 9);
        if (w <= 3)      rom_img[a] = {2'b00, 8'($urandom)};
        else if (w <= 6) rom_img[a] = {2'b01, 8'($urandom)};
        else if (w <= 8) rom_img[a] = {2'b10, 8'($urandom_range(0, 5))};
        else             rom_img[a] = END_E;
      end
      fill_ready(1);
      run_case($sformatf("rand%0d", r), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ili9341_init_seq.md
ILI9341_INIT_SEQ -- requirements
Module: ili9341_init_seq

Interface
REQ-001 The block SHALL have parameter N_ENTRIES, default 64, giving the number of init-ROM entries (min 2).
REQ-002 The block SHALL have parameter DW, default 8, giving the payload/bus data width (8 or 16).
REQ-003 The block SHALL have parameter DLY_UNIT, default 100000, giving clock cycles per delay tick (>=1).
REQ-004 The block SHALL have parameter RST_LOW, default 1000, giving lcd_rst_n low time in cycles (used only with INIT_HW_RESET_EN).
REQ-005 The block SHALL have parameter RST_WAIT, default 12000000, giving post-reset wait in cycles (used only with INIT_HW_RESET_EN).
REQ-006 The block SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 The block SHALL have port start, input, 1, one-cycle request to run the sequence.
REQ-009 The block SHALL have port rom_addr, output, AW=$clog2(N_ENTRIES), registered ROM read address.
REQ-010 The block SHALL have port rom_data, input, DW+2, ROM entry {type[1:0], payload[DW-1:0]}, valid one cycle after rom_addr.
REQ-011 The block SHALL have ports tx_valid out 1, tx_ready in 1, tx_dc out 1, tx_data out DW: byte/word handshake to the bus driver.
REQ-012 The block SHALL have ports busy out 1 (sequence running) and done out 1 (sequence finished).
REQ-013 The block SHALL have port lcd_rst_n, output, 1, panel hardware reset, active-low.

Function
REQ-014 Entry types SHALL be: 2'b00 command (tx_dc=0), 2'b01 data (tx_dc=1), 2'b10 delay (payload = ticks), 2'b11 end.
REQ-015 FSM states SHALL be IDLE, HWRST_LOW, HWRST_WAIT, FETCH, DECODE, SEND, DELAY, DONE.
REQ-016 start SHALL be accepted only in IDLE or DONE; in any other state it SHALL be ignored.
REQ-017 On accepted start: rom_addr<=0, done<=0, busy<=1, next state FETCH (or HWRST_LOW with macro).
REQ-018 FETCH SHALL last exactly one cycle; DECODE SHALL capture rom_data and branch on type.
REQ-019 With tx_ready held high, tx_valid SHALL rise 3 cycles after the start-sampling edge and 3 cycles after each accepted transfer.
REQ-020 In SEND, tx_valid, tx_dc, tx_data SHALL stay stable until tx_valid&tx_ready; transfer completes on that edge.
REQ-021 Delay entry with payload P SHALL hold in DELAY for exactly P*DLY_UNIT cycles, tx_valid=0; P=0 SHALL proceed without a DELAY cycle.
REQ-022 After a completed send or delay, if rom_addr==N_ENTRIES-1 the FSM SHALL go to DONE; otherwise rom_addr+1 and FETCH (no wrap).
REQ-023 An end entry SHALL go directly to DONE; nothing is sent.
REQ-024 In DONE: busy=0, done=1 until next accepted start; tx_valid=0.
REQ-025 Delay counter SHALL be wide enough for (2**DW-1)*DLY_UNIT without overflow.

Reset
REQ-026 rst SHALL asynchronously force state IDLE, rom_addr=0, tx_valid=0, tx_dc=0, tx_data=0, busy=0, done=0, lcd_rst_n=1, counters=0.
REQ-027 rst asserted mid-transfer SHALL drop tx_valid immediately; no entry is resumed after release.

Configuration
REQ-028 Macro INIT_HW_RESET_EN, when defined, SHALL insert HWRST_LOW (lcd_rst_n=0, RST_LOW cycles) then HWRST_WAIT (lcd_rst_n=1, RST_WAIT cycles) before the first FETCH; busy=1 throughout.
REQ-029 Without INIT_HW_RESET_EN, HWRST states and their counter SHALL not be built, lcd_rst_n SHALL be tied 1, and start SHALL go straight to FETCH.

Verification
REQ-030 ROM {00_CB, 01_39, 11_xx}, tx_ready=1, start pulse -> transfers (dc0,CB),(dc1,39); first tx_valid at start+3; done=1 after end entry.
REQ-031 tx_ready low 5 cycles during entry 00_11 -> tx_valid/tx_data=11/tx_dc=0 held constant 5 cycles, transferred once.
REQ-032 DLY_UNIT=4, entry 10_03 between two commands -> 12-cycle gap in DELAY plus fetch cycles; entry 10_00 adds no DELAY cycle.
REQ-033 N_ENTRIES=4, no end entry -> exactly 4 entries processed, rom_addr stops at 3, done=1; start pulse while busy ignored.
REQ-034 rst pulse while tx_valid=1 -> all outputs at reset values same cycle; new start restarts from rom_addr=0.
REQ-035 INIT_HW_RESET_EN, RST_LOW=3, RST_WAIT=5 -> lcd_rst_n low 3 cycles, high 5 cycles, then rom_addr=0 fetch.
